// File: rtl/vga_capture.sv
// VGA-style video sink: measures line and frame timing, locks onto it, then
// writes each active pixel into a linear framebuffer at address y*HSIZE + x.
module vga_capture #(
  parameter int   WIDTH = 12,
  parameter int   HSIZE = 800,
  parameter int   VSIZE = 600,
  parameter logic HSPP  = 1'b1,
  parameter logic VSPP  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             data_enable,
  input  logic [7:0]       red,
  input  logic [7:0]       green,
  input  logic [7:0]       blue,
  output logic             wr_en,
  output logic [18:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] h_total,
  output logic [WIDTH-1:0] v_total,
  output logic             locked,
  output logic             frame_done,
  output logic             err
);

  typedef enum logic [1:0] {SEEK, MEASURE, LOCKED} state_t;

  localparam logic [WIDTH-1:0] L_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] L_HSIZE = WIDTH'(HSIZE);
  localparam logic [WIDTH-1:0] L_VSIZE = WIDTH'(VSIZE);
  localparam logic [18:0]      L_HSTEP = 19'(HSIZE);

  state_t           r_state;
  logic             r_hs, r_vs, r_de;
  logic             r_hsPrev, r_vsPrev, r_dePrev;
  logic [23:0]      r_rgb;
  logic [WIDTH-1:0] r_lc, r_vc;
  logic [WIDTH-1:0] r_px, r_py;
  logic [WIDTH-1:0] r_hTotal, r_vTotal;
  logic [18:0]      r_addr, r_lineBase;
  logic             r_hStarted, r_hLatched, r_skipH;
  logic             r_wrEn;
  logic [18:0]      r_wrAddr;
  logic [31:0]      r_wrData;
  logic [WIDTH-1:0] r_x, r_y;
  logic             r_locked, r_frameDone, r_err;

  logic w_hEdge, w_vEdge, w_deFall, w_lcSat;
  logic w_hMis, w_vMis, w_fail, w_capture;

  // Every pin is registered once; the "Prev" copies give the edge history.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs     <= ~HSPP;
      r_vs     <= ~VSPP;
      r_de     <= 1'b0;
      r_hsPrev <= ~HSPP;
      r_vsPrev <= ~VSPP;
      r_dePrev <= 1'b0;
      r_rgb    <= 24'h0;
    end else begin
      r_hs     <= hsync;
      r_vs     <= vsync;
      r_de     <= data_enable;
      r_hsPrev <= r_hs;
      r_vsPrev <= r_vs;
      r_dePrev <= r_de;
      r_rgb    <= {red, green, blue};
    end
  end

  assign w_hEdge  = (r_hs == HSPP) && (r_hsPrev != HSPP);
  assign w_vEdge  = (r_vs == VSPP) && (r_vsPrev != VSPP);
  assign w_deFall = r_dePrev && !r_de;
  assign w_lcSat  = &r_lc;

  // The first hsync edge after a vsync edge is never compared against h_total.
  assign w_hMis    = w_hEdge && !w_vEdge && !r_skipH && (r_lc != r_hTotal);
  assign w_vMis    = w_vEdge && (r_vc != r_vTotal);
  assign w_fail    = (r_state == LOCKED) && (w_hMis || w_vMis || w_lcSat);
  assign w_capture = (r_state == LOCKED) && !w_fail && r_de &&
                     (r_px < L_HSIZE) && (r_py < L_VSIZE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lc <= '0;
      r_vc <= '0;
    end else begin
      if (w_hEdge) begin
        r_lc <= L_ONE;
      end else if (!w_lcSat) begin
        r_lc <= r_lc + L_ONE;
      end
      if (w_vEdge) begin
        r_vc <= '0;
      end else if (w_hEdge && !(&r_vc)) begin
        r_vc <= r_vc + L_ONE;
      end
    end
  end

  // Line base accumulates HSIZE per line so a short line still lands on y*HSIZE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_px       <= '0;
      r_py       <= '0;
      r_addr     <= '0;
      r_lineBase <= '0;
    end else begin
      if (w_hEdge) begin
        r_px <= '0;
      end else if (r_de && !(&r_px)) begin
        r_px <= r_px + L_ONE;
      end
      if (w_vEdge) begin
        r_py       <= '0;
        r_addr     <= '0;
        r_lineBase <= '0;
      end else if (w_deFall) begin
        if (!(&r_py)) begin
          r_py <= r_py + L_ONE;
        end
        if (r_py < L_VSIZE) begin
          r_lineBase <= r_lineBase + L_HSTEP;
          r_addr     <= r_lineBase + L_HSTEP;
        end
      end else if (w_capture) begin
        r_addr <= r_addr + 19'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= SEEK;
      r_hStarted  <= 1'b0;
      r_hLatched  <= 1'b0;
      r_skipH     <= 1'b0;
      r_hTotal    <= '0;
      r_vTotal    <= '0;
      r_locked    <= 1'b0;
      r_frameDone <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      r_err       <= 1'b0;
      if (w_vEdge) begin
        r_skipH <= 1'b1;
      end else if (w_hEdge) begin
        r_skipH <= 1'b0;
      end
      case (r_state)
        SEEK: begin
          r_locked <= 1'b0;
          if (w_vEdge && !w_lcSat) begin
            r_state    <= MEASURE;
            r_hStarted <= 1'b0;
            r_hLatched <= 1'b0;
          end
        end
        MEASURE: begin
          if (w_lcSat) begin
            r_state <= SEEK;
          end else if (w_vEdge) begin
            if (r_hLatched) begin
              r_vTotal <= r_vc;
              r_locked <= 1'b1;
              r_state  <= LOCKED;
            end else begin
              r_state <= SEEK;
            end
          end else if (w_hEdge) begin
            if (!r_hStarted) begin
              r_hStarted <= 1'b1;
            end else if (!r_hLatched) begin
              r_hTotal   <= r_lc;
              r_hLatched <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (w_vEdge) begin
            r_frameDone <= 1'b1;
          end
          if (w_fail) begin
            r_locked <= 1'b0;
            r_err    <= 1'b1;
            r_state  <= SEEK;
          end
        end
        default: begin
          r_locked <= 1'b0;
          r_state  <= SEEK;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrEn   <= 1'b0;
      r_wrAddr <= '0;
      r_wrData <= '0;
      r_x      <= '0;
      r_y      <= '0;
    end else begin
      r_wrEn <= w_capture;
      if (w_capture) begin
        r_wrAddr <= r_addr;
        r_wrData <= {8'h00, r_rgb};
        r_x      <= r_px;
        r_y      <= r_py;
      end
    end
  end

  assign wr_en      = r_wrEn;
  assign wr_addr    = r_wrAddr;
  assign wr_data    = r_wrData;
  assign x          = r_x;
  assign y          = r_y;
  assign h_total    = r_hTotal;
  assign v_total    = r_vTotal;
  assign locked     = r_locked;
  assign frame_done = r_frameDone;
  assign err        = r_err;

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture: drives synthetic VGA timing with random pixel data and
// compares captured writes and lock behaviour against a frame-level model.
module tb_vga_capture;

  localparam int HS = 8;
  localparam int VS = 4;

  typedef struct packed {
    logic [31:0] cyc;
    logic [18:0] addr;
    logic [11:0] xv;
    logic [11:0] yv;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int         cyc;
    int         line;
    int         col;
    logic [23:0] rgb;
  } px_t;

  logic clk = 1'b0;
  logic reset, hsync, vsync, de;
  logic [7:0] red, green, blue;

  logic        wrEn, lockedO, frameDone, errO;
  logic [18:0] wrAddr;
  logic [31:0] wrData;
  logic [11:0] xo, yo, hTot, vTot;

  logic        wrEnInv, lockedInv, frameDoneInv, errInv;
  logic [18:0] wrAddrInv;
  logic [31:0] wrDataInv;
  logic [11:0] xoInv, yoInv, hTotInv, vTotInv;

  int  cyc = 0;
  int  nChecks = 0;
  int  nPass = 0;
  int  errCnt = 0, errInvCnt = 0, fdCnt = 0, fdInvCnt = 0, errCyc = -1;
  logic errPrev = 1'b0;
  logic lockedAfterErr = 1'b1;

  int tL, tHs, tDeStart, tDeLen, tDeLines, tVLine, tLines;

  wr_t obsQ[$];
  wr_t obsInvQ[$];
  wr_t expQ[$];
  px_t drvQ[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_capture #(.WIDTH(12), .HSIZE(HS), .VSIZE(VS), .HSPP(1'b1), .VSPP(1'b1)) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .data_enable(de),
    .red(red), .green(green), .blue(blue),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .x(xo), .y(yo),
    .h_total(hTot), .v_total(vTot), .locked(lockedO), .frame_done(frameDone), .err(errO)
  );

  vga_capture #(.WIDTH(12), .HSIZE(HS), .VSIZE(VS), .HSPP(1'b0), .VSPP(1'b0)) dutInv (
    .clk(clk), .reset(reset), .hsync(~hsync), .vsync(~vsync), .data_enable(de),
    .red(red), .green(green), .blue(blue),
    .wr_en(wrEnInv), .wr_addr(wrAddrInv), .wr_data(wrDataInv), .x(xoInv), .y(yoInv),
    .h_total(hTotInv), .v_total(vTotInv), .locked(lockedInv), .frame_done(frameDoneInv),
    .err(errInv)
  );

  // Observation only: log writes and pulses; the test tasks do the judging.
  always @(negedge clk) begin
    if (wrEn) obsQ.push_back({cyc, wrAddr, xo, yo, wrData});
    if (wrEnInv) obsInvQ.push_back({cyc, wrAddrInv, xoInv, yoInv, wrDataInv});
    if (errPrev) lockedAfterErr = lockedO;
    errPrev = errO;
    if (errO) begin
      errCnt++;
      errCyc = cyc;
    end
    if (errInv) errInvCnt++;
    if (frameDone) fdCnt++;
    if (frameDoneInv) fdInvCnt++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] timeout");
  end

  task automatic setTiming(input int L, input int hs, input int deStart, input int deLen,
                           input int deLines, input int vLine, input int lines);
    tL = L; tHs = hs; tDeStart = deStart; tDeLen = deLen;
    tDeLines = deLines; tVLine = vLine; tLines = lines;
  endtask

  task automatic driveLines(input int first, input int last, input int longLine);
    for (int l = first; l <= last; l++) begin
      int len;
      len = (l == longLine) ? tL + 1 : tL;
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        hsync = (c == tHs) || (c == tHs + 1);
        vsync = (l == tVLine);
        de    = (l < tDeLines) && (c >= tDeStart) && (c < tDeStart + tDeLen);
        red   = 8'($urandom_range(0, 255));
        green = 8'($urandom_range(0, 255));
        blue  = 8'($urandom_range(0, 255));
        if (de) drvQ.push_back('{cyc, l, c - tDeStart, {red, green, blue}});
      end
    end
  endtask

  task automatic driveFrames(input int n);
    repeat (n) driveLines(0, tLines - 1, -1);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1; hsync = 1'b0; vsync = 1'b0; de = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference model: a pixel at (line, col) is stored iff col<HS and line<VS,
  // at address line*HS+col, two clocks after it was on the pins.
  task automatic modelWrites();
    expQ.delete();
    foreach (drvQ[i]) begin
      if (drvQ[i].col < HS && drvQ[i].line < VS)
        expQ.push_back({32'(drvQ[i].cyc + 2), 19'(drvQ[i].line * HS + drvQ[i].col),
                        12'(drvQ[i].col), 12'(drvQ[i].line), 8'h00, drvQ[i].rgb});
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    nChecks++;
    if ({wrEn, wrAddr, wrData, xo, yo, hTot, vTot, lockedO, frameDone, errO} !== '0)
      $display("[TB] FAIL reset_outputs: got wr_en=%b addr=%0d data=%h x=%0d y=%0d h=%0d v=%0d locked=%b fd=%b err=%b, expected all 0",
               wrEn, wrAddr, wrData, xo, yo, hTot, vTot, lockedO, frameDone, errO);
    else nPass++;
    nChecks++;
    if ({wrEnInv, wrAddrInv, wrDataInv, xoInv, yoInv, hTotInv, vTotInv, lockedInv, frameDoneInv, errInv} !== '0)
      $display("[TB] FAIL reset_outputs_inv: got locked=%b h=%0d v=%0d wr_en=%b, expected all 0",
               lockedInv, hTotInv, vTotInv, wrEnInv);
    else nPass++;
    reset = 1'b0;
  endtask

  task automatic test_lock();
    setTiming(12, 9, 0, 8, 4, 5, 7);
    doReset();
    errCnt = 0;
    driveFrames(1);
    nChecks++;
    if (lockedO !== 1'b0) $display("[TB] FAIL lock_early: got locked=%b, expected 0", lockedO);
    else nPass++;
    driveFrames(1);
    nChecks++;
    if (lockedO !== 1'b1) $display("[TB] FAIL lock_after_two_vsync: got locked=%b, expected 1", lockedO);
    else nPass++;
    nChecks++;
    if (hTot !== 12'(tL)) $display("[TB] FAIL lock_h_total: got %0d, expected %0d", hTot, tL);
    else nPass++;
    nChecks++;
    if (vTot !== 12'(tLines)) $display("[TB] FAIL lock_v_total: got %0d, expected %0d", vTot, tLines);
    else nPass++;
    nChecks++;
    if (errCnt !== 0) $display("[TB] FAIL lock_no_err: got %0d err pulses, expected 0", errCnt);
    else nPass++;
  endtask

  task automatic test_capture();
    drvQ.delete();
    obsQ.delete();
    fdCnt = 0;
    driveFrames(1);
    modelWrites();
    nChecks++;
    if (obsQ.size() !== expQ.size())
      $display("[TB] FAIL capture_count: got %0d writes, expected %0d", obsQ.size(), expQ.size());
    else nPass++;
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      nChecks++;
      if (obsQ[i] !== expQ[i])
        $display("[TB] FAIL capture_write[%0d]: got cyc=%0d addr=%0d x=%0d y=%0d data=%h, expected cyc=%0d addr=%0d x=%0d y=%0d data=%h",
                 i, obsQ[i].cyc, obsQ[i].addr, obsQ[i].xv, obsQ[i].yv, obsQ[i].data,
                 expQ[i].cyc, expQ[i].addr, expQ[i].xv, expQ[i].yv, expQ[i].data);
      else nPass++;
    end
    nChecks++;
    if (fdCnt !== 1) $display("[TB] FAIL capture_frame_done: got %0d pulses, expected 1", fdCnt);
    else nPass++;
  endtask

  task automatic test_line_error();
    int late;
    errCnt = 0;
    errCyc = -1;
    lockedAfterErr = 1'b1;
    obsQ.delete();
    driveLines(0, tLines - 1, 1);
    nChecks++;
    if (errCnt !== 1) $display("[TB] FAIL line_err_pulse: got %0d err cycles, expected 1", errCnt);
    else nPass++;
    nChecks++;
    if (lockedAfterErr !== 1'b0)
      $display("[TB] FAIL line_err_locked_drop: got locked=%b after err, expected 0", lockedAfterErr);
    else nPass++;
    nChecks++;
    if (lockedO !== 1'b0) $display("[TB] FAIL line_err_one_vsync: got locked=%b, expected 0", lockedO);
    else nPass++;
    driveFrames(1);
    late = 0;
    foreach (obsQ[i]) if (int'(obsQ[i].cyc) > errCyc) late++;
    nChecks++;
    if (late !== 0) $display("[TB] FAIL line_err_no_writes: got %0d writes before relock, expected 0", late);
    else nPass++;
    nChecks++;
    if (lockedO !== 1'b1) $display("[TB] FAIL line_err_relock: got locked=%b, expected 1", lockedO);
    else nPass++;
    nChecks++;
    if (hTot !== 12'(tL)) $display("[TB] FAIL line_err_h_total: got %0d, expected %0d", hTot, tL);
    else nPass++;
  endtask

  task automatic test_oversize();
    setTiming(14, 11, 0, 10, 6, 6, 7);
    doReset();
    driveFrames(2);
    nChecks++;
    if (lockedO !== 1'b1 || hTot !== 12'(tL) || vTot !== 12'(tLines))
      $display("[TB] FAIL oversize_lock: got locked=%b h=%0d v=%0d, expected 1 %0d %0d",
               lockedO, hTot, vTot, tL, tLines);
    else nPass++;
    drvQ.delete();
    obsQ.delete();
    driveFrames(1);
    modelWrites();
    nChecks++;
    if (obsQ.size() !== expQ.size())
      $display("[TB] FAIL oversize_count: got %0d writes, expected %0d", obsQ.size(), expQ.size());
    else nPass++;
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      nChecks++;
      if (obsQ[i] !== expQ[i])
        $display("[TB] FAIL oversize_write[%0d]: got cyc=%0d addr=%0d x=%0d y=%0d data=%h, expected cyc=%0d addr=%0d x=%0d y=%0d data=%h",
                 i, obsQ[i].cyc, obsQ[i].addr, obsQ[i].xv, obsQ[i].yv, obsQ[i].data,
                 expQ[i].cyc, expQ[i].addr, expQ[i].xv, expQ[i].yv, expQ[i].data);
      else nPass++;
    end
  endtask

  task automatic test_reset_midframe();
    errCnt = 0;
    driveLines(0, 2, -1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    nChecks++;
    if ({wrEn, wrAddr, wrData, xo, yo, hTot, vTot, lockedO, frameDone, errO} !== '0)
      $display("[TB] FAIL midframe_reset_outputs: got wr_en=%b addr=%0d x=%0d y=%0d h=%0d v=%0d locked=%b, expected all 0",
               wrEn, wrAddr, xo, yo, hTot, vTot, lockedO);
    else nPass++;
    reset = 1'b0;
    driveLines(3, tLines - 1, -1);
    nChecks++;
    if (lockedO !== 1'b0) $display("[TB] FAIL midframe_seek: got locked=%b, expected 0", lockedO);
    else nPass++;
    driveFrames(1);
    nChecks++;
    if (lockedO !== 1'b1 || hTot !== 12'(tL) || vTot !== 12'(tLines))
      $display("[TB] FAIL midframe_relock: got locked=%b h=%0d v=%0d, expected 1 %0d %0d",
               lockedO, hTot, vTot, tL, tLines);
    else nPass++;
    nChecks++;
    if (errCnt !== 0) $display("[TB] FAIL midframe_no_err: got %0d err pulses, expected 0", errCnt);
    else nPass++;
  endtask

  task automatic test_inverted();
    setTiming(12, 0, 2, 8, 4, 5, 8);
    doReset();
    errInvCnt = 0;
    driveFrames(2);
    nChecks++;
    if (lockedInv !== 1'b1) $display("[TB] FAIL inv_lock: got locked=%b, expected 1", lockedInv);
    else nPass++;
    nChecks++;
    if (hTotInv !== 12'(tL)) $display("[TB] FAIL inv_h_total: got %0d, expected %0d", hTotInv, tL);
    else nPass++;
    // The hsync edge coinciding with vsync is not counted, so one line fewer.
    nChecks++;
    if (vTotInv !== 12'(tLines - 1))
      $display("[TB] FAIL inv_v_total: got %0d, expected %0d", vTotInv, tLines - 1);
    else nPass++;
    fdInvCnt = 0;
    obsInvQ.delete();
    drvQ.delete();
    driveFrames(3);
    modelWrites();
    nChecks++;
    if (fdInvCnt !== 3) $display("[TB] FAIL inv_frame_done: got %0d pulses, expected 3", fdInvCnt);
    else nPass++;
    nChecks++;
    if (errInvCnt !== 0 || lockedInv !== 1'b1)
      $display("[TB] FAIL inv_stable: got err=%0d locked=%b, expected 0 and 1", errInvCnt, lockedInv);
    else nPass++;
    nChecks++;
    if (obsInvQ.size() !== expQ.size())
      $display("[TB] FAIL inv_count: got %0d writes, expected %0d", obsInvQ.size(), expQ.size());
    else nPass++;
    for (int i = 0; i < expQ.size() && i < obsInvQ.size(); i++) begin
      nChecks++;
      if (obsInvQ[i] !== expQ[i])
        $display("[TB] FAIL inv_write[%0d]: got cyc=%0d addr=%0d x=%0d y=%0d data=%h, expected cyc=%0d addr=%0d x=%0d y=%0d data=%h",
                 i, obsInvQ[i].cyc, obsInvQ[i].addr, obsInvQ[i].xv, obsInvQ[i].yv, obsInvQ[i].data,
                 expQ[i].cyc, expQ[i].addr, expQ[i].xv, expQ[i].yv, expQ[i].data);
      else nPass++;
    end
  endtask

  initial begin
    reset = 1'b1; hsync = 1'b0; vsync = 1'b0; de = 1'b0;
    red = 8'h0; green = 8'h0; blue = 8'h0;
    test_reset();
    test_lock();
    test_capture();
    test_line_error();
    test_oversize();
    test_reset_midframe();
    test_inverted();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Sink-side counterpart of the VGA timing generator. Accepts hsync, vsync and data_enable plus 8-bit RGB from an external VGA-style source, all on the local clock.
- Measures line and frame timing and locks onto it, then recovers pixel coordinates.
- Writes each active pixel into the 32-bit framebuffer through a write port, packed linearly as address = y*HSIZE + x.
- Sits between the video input pins and the framebuffer RAM write side.

Parameters:
- WIDTH, 12, bit width of x, y and timing counters.
- HSIZE, 800, active pixels per line stored; extra pixels are dropped.
- VSIZE, 600, active lines per frame stored; extra lines are dropped.
- HSPP, 1, hsync pulse polarity (0 negative, 1 positive).
- VSPP, 1, vsync pulse polarity (0 negative, 1 positive).

Ports:
- clk  input  1  single system/pixel clock.
- reset  input  1  synchronous, active-high reset.
- hsync  input  1  incoming horizontal sync, polarity HSPP.
- vsync  input  1  incoming vertical sync, polarity VSPP.
- data_enable  input  1  incoming active-video flag.
- red  input  8  pixel red.
- green  input  8  pixel green.
- blue  input  8  pixel blue.
- wr_en  output  1  framebuffer write strobe.
- wr_addr  output  19  framebuffer word address.
- wr_data  output  32  {8'h00, red, green, blue}.
- x  output  WIDTH  column of the current write.
- y  output  WIDTH  line of the current write.
- h_total  output  WIDTH  measured clocks per line.
- v_total  output  WIDTH  measured lines per frame.
- locked  output  1  timing locked; capture active.
- frame_done  output  1  one-cycle pulse at each vsync edge while locked.
- err  output  1  one-cycle pulse on loss of lock.

Behaviour:
- Reset is synchronous and active-high. On reset:
  - all outputs are 0, including h_total and v_total;
  - the FSM goes to SEEK;
  - the input register stage and edge history are cleared to the inactive levels (!HSPP, !VSPP, de=0).
- Input stage:
  - All inputs are registered once.
  - An hsync edge is an inactive→active transition of the registered hsync versus its previous sample. A vsync edge is defined the same way.
  - A de fall is a 1→0 transition of registered de.
- Line counter lc:
  - Increments every clock.
  - Loaded with 1 on an hsync edge.
  - Saturates at all ones.
- Line count vc:
  - Increments on each hsync edge.
  - Loaded with 0 on a vsync edge.
  - If a vsync edge and an hsync edge occur in the same clock, the vsync edge wins: vc=0, and that line is counted from the next hsync edge.
- FSM SEEK:
  - Wait for a vsync edge, then go to MEASURE.
  - lc saturating in any non-LOCKED state forces a return to SEEK.
- FSM MEASURE:
  - At the first hsync edge after entry, start line timing.
  - At the second hsync edge, latch h_total = lc.
  - At the next vsync edge, latch v_total = vc (the value before clearing), set locked=1, and go to LOCKED.
  - A vsync edge arriving before h_total is latched returns the FSM to SEEK.
- FSM LOCKED:
  - Compare lc with h_total at every hsync edge except the first edge after a vsync edge. Compare vc with v_total at every vsync edge.
  - Any mismatch, or lc saturating, clears locked the next cycle, pulses err for 1 cycle, and returns the FSM to SEEK.
  - Tolerance is exact.
- Capture (LOCKED only):
  - Each registered-de=1 cycle with x<HSIZE and y<VSIZE produces wr_en=1 on the following clock, with wr_data, wr_addr, x and y for that pixel.
  - Total latency is 2 clocks from input pins to wr_en.
  - wr_en is 0 otherwise; wr_addr, wr_data, x and y hold their last values.
- Pixel and line counters:
  - The pixel column counter clears on an hsync edge and increments per de cycle.
  - The line index clears on a vsync edge and increments on each de fall.
  - Pixels with column ≥HSIZE, and lines ≥VSIZE, are dropped silently.
- Address generation:
  - A running 19-bit counter clears on a vsync edge and increments only on performed writes.
  - The counter does not increment across dropped pixels.
  - For a short line, the next line's first address is y*HSIZE. The counter reloads to y*HSIZE at each line start, computed by accumulation with no multiplier.
- frame_done pulses on the same cycle the vsync edge is processed in LOCKED. This includes the frame that causes a v_total mismatch, which also raises err.
- A vsync edge while the FSM is going from MEASURE to LOCKED starts the first captured frame, so no frame is skipped.

Test Plan:
1. Reset, then feed clean timing with HSIZE=8, VSIZE=4, a 12-clock line (hsync active at clocks 9-10) and 7 lines per frame (vsync active on line 5) → locked=1 after the second vsync edge; h_total=12 and v_total=7.
2. Locked, then one full frame → exactly 32 wr_en pulses; wr_addr runs 0..31 contiguously; the first write is at x=0, y=0; wr_data={8'h00,R,G,B} of the sampled pixel, 2 clocks after the pins.
3. Locked, then one line lengthened to 13 clocks → err pulses 1 cycle and locked drops the next cycle. wr_en stays 0 until relock, which happens after two further vsync edges.
4. Source with 10 de cycles per line and 6 de lines → only x<8 and y<4 are written (32 writes); addresses stay 0..31 with no gaps.
5. Assert reset mid-frame while locked → next cycle all outputs are 0 and the FSM is in SEEK. The following clean frames relock with identical h_total and v_total.
6. Inverted polarity (HSPP=0, VSPP=0), and a vsync edge coincident with an hsync edge → locks with v_total=7; frame_done pulses once per frame.
